// File: rtl/nand_cpu_pkg.sv
// Shared types for the NAND CPU pipeline: ALU operation encoding.
package nand_cpu_pkg;
   typedef enum logic [2:0] {
      ALU_CLR,
      ALU_CP,
      ALU_NAND,
      ALU_LS,
      ALU_RS,
      ALU_EQ,
      ALU_NE,
      ALU_LI
   } ALU_OP;
endpackage

// File: rtl/decode_stage.sv
// Decode stage: 8-bit instruction decode into a one-deep output register with handshake.
// Optional register/accumulator scoreboard enabled by macro DECODE_SCOREBOARD_EN.
module decode_stage
   import nand_cpu_pkg::*;
#(
   parameter int NUM_REG = 16,
   parameter int PC_W    = 8,
   parameter int RW      = $clog2(NUM_REG)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [7:0]      in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic            read_a,
   output logic            write_a,
   output logic            read_r,
   output logic            write_r,
   output logic            use_immdt,
   output logic [RW-1:0]   r,
   output logic [3:0]      immdt,
   output logic [1:0]      shift,
   output ALU_OP           alu_op,
   output logic            is_br,
   output logic            is_jrl,
   output logic            is_ld,
   output logic            is_st,
   output logic            interrupt,
   output logic            halt,
   output logic            illegal,
   input  logic            wb_a,
   input  logic            wb_r_valid,
   input  logic [RW-1:0]   wb_r,
   input  logic            flush,
   output logic            halted
);

   typedef struct packed {
      logic          read_a;
      logic          write_a;
      logic          read_r;
      logic          write_r;
      logic          use_immdt;
      logic [RW-1:0] r;
      logic [3:0]    immdt;
      logic [1:0]    shift;
      ALU_OP         alu_op;
      logic          is_br;
      logic          is_jrl;
      logic          is_ld;
      logic          is_st;
      logic          interrupt;
      logic          halt;
      logic          illegal;
   } dec_t;

   typedef enum logic [1:0] {S_RUN, S_STALL, S_HALTED} state_t;

   dec_t            w_dec, r_dec;
   logic [PC_W-1:0] r_pc;
   logic            r_out_valid;
   state_t          r_state, w_state_nxt;
   logic            w_in_ready, w_take, w_xfer, w_halt_set, w_hazard;

   always_comb begin
      w_dec           = '0;
      w_dec.r         = in_instr[RW-1:0];
      w_dec.immdt     = in_instr[3:0];
      w_dec.shift     = in_instr[5:4];
      w_dec.alu_op    = ALU_CLR;
      case (in_instr[7:4])
         4'h0: begin
            if (in_instr[3:0] == 4'd0) begin
               w_dec.write_a = 1'b1;
            end else begin
               w_dec.read_a  = 1'b1;
               w_dec.write_r = 1'b1;
               w_dec.alu_op  = ALU_CP;
            end
         end
         4'h1: begin w_dec.read_a = 1'b1; w_dec.write_a = 1'b1; w_dec.read_r = 1'b1; w_dec.alu_op = ALU_NAND; end
         4'h2: begin w_dec.read_a = 1'b1; w_dec.write_a = 1'b1; w_dec.read_r = 1'b1; w_dec.alu_op = ALU_LS; end
         4'h3: begin w_dec.read_a = 1'b1; w_dec.write_a = 1'b1; w_dec.read_r = 1'b1; w_dec.alu_op = ALU_RS; end
         4'h4: begin w_dec.read_a = 1'b1; w_dec.read_r = 1'b1; w_dec.alu_op = ALU_EQ; end
         4'h5: begin w_dec.read_a = 1'b1; w_dec.read_r = 1'b1; w_dec.alu_op = ALU_NE; end
         4'h6: begin w_dec.read_r = 1'b1; w_dec.is_br = 1'b1; end
         4'h7: begin w_dec.read_r = 1'b1; w_dec.write_r = 1'b1; w_dec.is_jrl = 1'b1; end
         4'h8, 4'h9, 4'hA, 4'hB: begin
            w_dec.read_a    = 1'b1;
            w_dec.write_a   = 1'b1;
            w_dec.use_immdt = 1'b1;
            w_dec.alu_op    = ALU_LI;
         end
         4'hC: begin w_dec.read_a = 1'b1; w_dec.write_a = 1'b1; w_dec.read_r = 1'b1; w_dec.is_ld = 1'b1; end
         4'hD: begin w_dec.read_a = 1'b1; w_dec.read_r = 1'b1; w_dec.is_st = 1'b1; end
         4'hE: begin w_dec.use_immdt = 1'b1; w_dec.interrupt = 1'b1; end
         4'hF: begin w_dec.use_immdt = 1'b1; w_dec.halt = 1'b1; end
         default: ;
      endcase
      // Register index bits above the implemented file size make the instruction illegal.
      if ((w_dec.read_r || w_dec.write_r) && ((in_instr[3:0] >> RW) != 4'd0)) begin
         w_dec.illegal   = 1'b1;
         w_dec.read_a    = 1'b0;
         w_dec.write_a   = 1'b0;
         w_dec.read_r    = 1'b0;
         w_dec.write_r   = 1'b0;
         w_dec.is_br     = 1'b0;
         w_dec.is_jrl    = 1'b0;
         w_dec.is_ld     = 1'b0;
         w_dec.is_st     = 1'b0;
         w_dec.interrupt = 1'b0;
         w_dec.halt      = 1'b0;
      end
   end

   // A flushed instruction never counts as transferred.
   assign w_xfer     = r_out_valid && out_ready && !flush;
   assign w_halt_set = w_xfer && r_dec.halt;
   assign w_take     = in_valid && w_in_ready;

`ifdef DECODE_SCOREBOARD_EN
   logic [NUM_REG-1:0] r_pend_r, w_clr_r, w_pend_r;
   logic               r_pend_a, w_pend_a;

   always_comb begin
      w_clr_r = '0;
      if (wb_r_valid) w_clr_r[wb_r] = 1'b1;
      w_pend_r = r_pend_r & ~w_clr_r;
      w_pend_a = r_pend_a && !wb_a;
   end

   assign w_hazard = in_valid &&
      ((w_dec.read_r && (w_pend_r[w_dec.r] || (r_out_valid && r_dec.write_r && (r_dec.r == w_dec.r)))) ||
       (w_dec.read_a && (w_pend_a || (r_out_valid && r_dec.write_a))));

   // Clears are applied first so a same-cycle set wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend_r <= '0;
         r_pend_a <= 1'b0;
      end else begin
         r_pend_r <= w_pend_r | ((w_xfer && r_dec.write_r) ? (NUM_REG'(1) << r_dec.r) : '0);
         r_pend_a <= w_pend_a || (w_xfer && r_dec.write_a);
      end
   end
`else
   logic w_unused_wb;
   assign w_unused_wb = ^{wb_a, wb_r_valid, wb_r};
   assign w_hazard    = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      case (r_state)
         S_RUN, S_STALL: begin
            w_in_ready = !(r_out_valid && r_dec.halt) && (!r_out_valid || out_ready) &&
                         !w_hazard && !flush && !rst;
            if (w_halt_set)    w_state_nxt = S_HALTED;
            else if (w_hazard) w_state_nxt = S_STALL;
            else               w_state_nxt = S_RUN;
         end
         S_HALTED: w_state_nxt = S_HALTED;
         default:  w_state_nxt = S_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_RUN;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_dec       <= '0;
         r_pc        <= '0;
      end else if (w_take) begin
         r_out_valid <= 1'b1;
         r_dec       <= w_dec;
         r_pc        <= in_pc;
      end else if (w_xfer || flush) begin
         r_out_valid <= 1'b0;
      end
   end

   assign in_ready  = w_in_ready;
   assign halted    = (r_state == S_HALTED);
   assign out_valid = r_out_valid;
   assign out_pc    = r_pc;
   assign read_a    = r_dec.read_a;
   assign write_a   = r_dec.write_a;
   assign read_r    = r_dec.read_r;
   assign write_r   = r_dec.write_r;
   assign use_immdt = r_dec.use_immdt;
   assign r         = r_dec.r;
   assign immdt     = r_dec.immdt;
   assign shift     = r_dec.shift;
   assign alu_op    = r_dec.alu_op;
   assign is_br     = r_dec.is_br;
   assign is_jrl    = r_dec.is_jrl;
   assign is_ld     = r_dec.is_ld;
   assign is_st     = r_dec.is_st;
   assign interrupt = r_dec.interrupt;
   assign halt      = r_dec.halt;
   assign illegal   = r_dec.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic against a table-driven model.
module tb_decode_stage;
   import nand_cpu_pkg::*;

   logic       clk = 1'b0;
   logic       rst, in_valid, out_ready, flush, wb_a, wb_r_valid;
   logic [7:0] in_instr, in_pc;
   logic [3:0] wb_r;

   logic       in_ready, out_valid, read_a, write_a, read_r, write_r, use_immdt;
   logic [7:0] out_pc;
   logic [3:0] r, immdt;
   logic [1:0] shift;
   ALU_OP      alu_op;
   logic       is_br, is_jrl, is_ld, is_st, interrupt, halt, illegal, halted;

   logic       q_in_ready, q_out_valid, q_read_a, q_write_a, q_read_r, q_write_r, q_use_immdt;
   logic [7:0] q_out_pc;
   logic [1:0] q_r;
   logic [3:0] q_immdt;
   logic [1:0] q_shift;
   ALU_OP      q_alu_op;
   logic       q_is_br, q_is_jrl, q_is_ld, q_is_st, q_interrupt, q_halt, q_illegal, q_halted;

   int checks = 0;
   int failures = 0;

   decode_stage #(.NUM_REG(16), .PC_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .read_a(read_a), .write_a(write_a), .read_r(read_r), .write_r(write_r),
      .use_immdt(use_immdt), .r(r), .immdt(immdt), .shift(shift), .alu_op(alu_op),
      .is_br(is_br), .is_jrl(is_jrl), .is_ld(is_ld), .is_st(is_st), .interrupt(interrupt),
      .halt(halt), .illegal(illegal), .wb_a(wb_a), .wb_r_valid(wb_r_valid), .wb_r(wb_r),
      .flush(flush), .halted(halted)
   );

   decode_stage #(.NUM_REG(4), .PC_W(8)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(q_in_ready), .in_instr(in_instr),
      .in_pc(in_pc), .out_valid(q_out_valid), .out_ready(out_ready), .out_pc(q_out_pc),
      .read_a(q_read_a), .write_a(q_write_a), .read_r(q_read_r), .write_r(q_write_r),
      .use_immdt(q_use_immdt), .r(q_r), .immdt(q_immdt), .shift(q_shift), .alu_op(q_alu_op),
      .is_br(q_is_br), .is_jrl(q_is_jrl), .is_ld(q_is_ld), .is_st(q_is_st),
      .interrupt(q_interrupt), .halt(q_halt), .illegal(q_illegal), .wb_a(wb_a),
      .wb_r_valid(wb_r_valid), .wb_r(wb_r[1:0]), .flush(flush), .halted(q_halted)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rd_a, wr_a, rd_r, wr_r, imm;
      logic [3:0] r;
      logic [3:0] immdt;
      logic [1:0] shift;
      ALU_OP      alu;
      logic       br, jrl, ld, st, intr, hlt, ill;
   } exp_t;

   typedef enum {M_CL, M_CP, M_NND, M_LS, M_RS, M_EQ, M_NE, M_BR, M_JRL, M_LI, M_LD, M_ST, M_INT, M_HLT} mn_t;

   function automatic exp_t ref_decode(input logic [7:0] ins, input int nreg);
      exp_t       e;
      mn_t        m;
      logic [4:0] en;
      e = '0;
      if (ins == 8'h00) m = M_CL;
      else begin
         case (ins[7:4])
            4'h0: m = M_CP;   4'h1: m = M_NND;  4'h2: m = M_LS;  4'h3: m = M_RS;
            4'h4: m = M_EQ;   4'h5: m = M_NE;   4'h6: m = M_BR;  4'h7: m = M_JRL;
            4'hC: m = M_LD;   4'hD: m = M_ST;   4'hE: m = M_INT; 4'hF: m = M_HLT;
            default: m = M_LI;
         endcase
      end
      case (m)
         M_CL:                     en = 5'b01000;
         M_CP:                     en = 5'b10010;
         M_NND, M_LS, M_RS, M_LD:  en = 5'b11100;
         M_EQ, M_NE, M_ST:         en = 5'b10100;
         M_BR:                     en = 5'b00100;
         M_JRL:                    en = 5'b00110;
         M_LI:                     en = 5'b11001;
         default:                  en = 5'b00001;
      endcase
      {e.rd_a, e.wr_a, e.rd_r, e.wr_r, e.imm} = en;
      case (m)
         M_CP: e.alu = ALU_CP;   M_NND: e.alu = ALU_NAND; M_LS: e.alu = ALU_LS;
         M_RS: e.alu = ALU_RS;   M_EQ:  e.alu = ALU_EQ;   M_NE: e.alu = ALU_NE;
         M_LI: e.alu = ALU_LI;   default: e.alu = ALU_CLR;
      endcase
      e.br = (m == M_BR); e.jrl = (m == M_JRL); e.ld = (m == M_LD); e.st = (m == M_ST);
      e.intr = (m == M_INT); e.hlt = (m == M_HLT);
      e.r = 4'(int'(ins[3:0]) % nreg);
      e.immdt = ins[3:0];
      e.shift = ins[5:4];
      if ((e.rd_r || e.wr_r) && int'(ins[3:0]) >= nreg) begin
         e.ill = 1'b1;
         {e.rd_a, e.wr_a, e.rd_r, e.wr_r} = 4'b0000;
         {e.br, e.jrl, e.ld, e.st, e.intr, e.hlt} = 6'b000000;
      end
      return e;
   endfunction

   function automatic exp_t got16();
      return exp_t'({read_a, write_a, read_r, write_r, use_immdt, r, immdt, shift, alu_op,
                     is_br, is_jrl, is_ld, is_st, interrupt, halt, illegal});
   endfunction

   function automatic exp_t got4();
      return exp_t'({q_read_a, q_write_a, q_read_r, q_write_r, q_use_immdt, 2'b00, q_r, q_immdt,
                     q_shift, q_alu_op, q_is_br, q_is_jrl, q_is_ld, q_is_st, q_interrupt, q_halt, q_illegal});
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      wb_a = 1'b0; wb_r_valid = 1'b0; wb_r = 4'd0; in_instr = 8'h00; in_pc = 8'h00;
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      in_instr = 8'hA7; in_pc = 8'h55; in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_instr = 8'h00; out_ready = 1'b1; rst = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
      checks++; if (got16() !== exp_t'('0) || out_pc !== 8'h00) begin
         failures++; $display("FAIL reset_fields got=%h pc=%h exp=0", got16(), out_pc); end
      rst = 1'b0; in_valid = 1'b0;
      #1;
   endtask

   task automatic test_clear();
      do_reset();
      in_instr = 8'h00; in_pc = 8'h42; in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL cl_in_ready got=%b exp=1", in_ready); end
      step();
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || write_a !== 1'b1 || alu_op !== ALU_CLR) begin
         failures++; $display("FAIL cl_decode got v=%b wa=%b alu=%0d exp v=1 wa=1 alu=0", out_valid, write_a, alu_op); end
      checks++; if (got16() !== ref_decode(8'h00, 16) || out_pc !== 8'h42) begin
         failures++; $display("FAIL cl_fields got=%h pc=%h exp=%h pc=42", got16(), out_pc, ref_decode(8'h00, 16)); end
      out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL cl_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_hold();
      exp_t e;
      e = ref_decode(8'hA7, 16);
      do_reset();
      in_instr = 8'hA7; in_pc = 8'h3C; in_valid = 1'b1;
      step();
      in_instr = 8'h22; in_pc = 8'h99;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", k, in_ready); end
         checks++; if (out_valid !== 1'b1 || got16() !== e || out_pc !== 8'h3C) begin
            failures++; $display("FAIL hold_stable cyc=%0d got v=%b %h pc=%h exp v=1 %h pc=3c", k, out_valid, got16(), out_pc, e); end
         step();
      end
      checks++; if (use_immdt !== 1'b1 || immdt !== 4'd7 || shift !== 2'd2) begin
         failures++; $display("FAIL hold_li got imm=%b immdt=%0d shift=%0d exp 1 7 2", use_immdt, immdt, shift); end
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_hazard();
      do_reset();
      out_ready = 1'b1; in_instr = 8'h05; in_pc = 8'h10; in_valid = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hz_cp_accept got=%b exp=1", in_ready); end
      step();
      in_instr = 8'h15; in_pc = 8'h11;
      #1;
`ifdef DECODE_SCOREBOARD_EN
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hz_outreg got=%b exp=0", in_ready); end
      step();
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hz_pending got=%b exp=0", in_ready); end
      wb_r_valid = 1'b1; wb_r = 4'd4;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hz_wrong_wb got=%b exp=0", in_ready); end
      step();
      wb_r = 4'd5;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hz_wb_release got=%b exp=1", in_ready); end
`else
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hz_disabled got=%b exp=1", in_ready); end
`endif
      step();
      in_valid = 1'b0; wb_r_valid = 1'b0; out_ready = 1'b0;
      checks++; if (out_valid !== 1'b1 || got16() !== ref_decode(8'h15, 16) || out_pc !== 8'h11) begin
         failures++; $display("FAIL hz_nnd_fields got v=%b %h pc=%h exp v=1 %h pc=11", out_valid, got16(), out_pc, ref_decode(8'h15, 16)); end
   endtask

   task automatic test_num_reg4();
      do_reset();
      out_ready = 1'b1; in_instr = 8'h17; in_pc = 8'h20; in_valid = 1'b1;
      #1;
      checks++; if (q_in_ready !== 1'b1) begin failures++; $display("FAIL nr4_accept got=%b exp=1", q_in_ready); end
      step();
      in_valid = 1'b0;
      checks++; if (q_out_valid !== 1'b1 || q_illegal !== 1'b1 || q_read_r !== 1'b0) begin
         failures++; $display("FAIL nr4_illegal got v=%b ill=%b rr=%b exp 1 1 0", q_out_valid, q_illegal, q_read_r); end
      checks++; if (got4() !== ref_decode(8'h17, 4)) begin
         failures++; $display("FAIL nr4_illegal_fields got=%h exp=%h", got4(), ref_decode(8'h17, 4)); end
      do_reset();
      out_ready = 1'b1; in_instr = 8'h13; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      checks++; if (q_illegal !== 1'b0 || q_r !== 2'd3 || q_read_r !== 1'b1) begin
         failures++; $display("FAIL nr4_legal got ill=%b r=%0d rr=%b exp 0 3 1", q_illegal, q_r, q_read_r); end
      checks++; if (got4() !== ref_decode(8'h13, 4)) begin
         failures++; $display("FAIL nr4_legal_fields got=%h exp=%h", got4(), ref_decode(8'h13, 4)); end
   endtask

   task automatic test_halt();
      do_reset();
      in_instr = 8'hF0; in_pc = 8'h30; in_valid = 1'b1;
      step();
      in_instr = 8'h00;
      checks++; if (out_valid !== 1'b1 || halt !== 1'b1) begin
         failures++; $display("FAIL hlt_held got v=%b halt=%b exp 1 1", out_valid, halt); end
      flush = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hlt_flush_in_ready got=%b exp=0", in_ready); end
      step();
      flush = 1'b0;
      checks++; if (out_valid !== 1'b0 || halted !== 1'b0) begin
         failures++; $display("FAIL hlt_flushed got v=%b halted=%b exp 0 0", out_valid, halted); end
      in_instr = 8'hF0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL hlt_reissue got=%b exp=1", in_ready); end
      step();
      in_instr = 8'h00; out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hlt_block_behind got=%b exp=0", in_ready); end
      step();
      checks++; if (halted !== 1'b1 || out_valid !== 1'b0) begin
         failures++; $display("FAIL hlt_halted got halted=%b v=%b exp 1 0", halted, out_valid); end
      for (int k = 0; k < 3; k++) begin
         checks++; if (in_ready !== 1'b0 || halted !== 1'b1) begin
            failures++; $display("FAIL hlt_sticky cyc=%0d got rdy=%b halted=%b exp 0 1", k, in_ready, halted); end
         step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      checks++; if (halted !== 1'b0 || in_ready !== 1'b1) begin
         failures++; $display("FAIL hlt_reset got halted=%b rdy=%b exp 0 1", halted, in_ready); end
      in_valid = 1'b0; out_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b1; in_instr = 8'h05; in_valid = 1'b1;
      step();
      in_instr = 8'h01;
      step();
      out_ready = 1'b0; in_instr = 8'h15; rst = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_in_ready got=%b exp=0", in_ready); end
      step();
      rst = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++; $display("FAIL mid_rst_residue got v=%b rdy=%b exp 0 1", out_valid, in_ready); end
      in_valid = 1'b0;
   endtask

   task automatic test_random();
      exp_t       m_held, d;
      logic       m_ov, exp_rdy, hz, take, xfer;
      logic [7:0] m_pc;
      bit         m_pa;
      bit         m_pr [16];
      do_reset();
      m_held = '0; m_ov = 1'b0; m_pc = 8'h00; m_pa = 1'b0;
      foreach (m_pr[k]) m_pr[k] = 1'b0;
      for (int n = 0; n < 400; n++) begin
         checks++; if (out_valid !== m_ov) begin
            failures++; $display("FAIL rand_out_valid n=%0d got=%b exp=%b", n, out_valid, m_ov); end
         checks++; if (got16() !== m_held || out_pc !== m_pc) begin
            failures++; $display("FAIL rand_fields n=%0d got=%h pc=%h exp=%h pc=%h", n, got16(), out_pc, m_held, m_pc); end
         in_valid = ($urandom_range(0, 3) != 0);
         in_instr = 8'($urandom);
         if (in_instr[7:4] == 4'hF) in_instr[7:4] = 4'hE;
         in_pc = 8'($urandom);
         out_ready = ($urandom_range(0, 2) != 0);
         flush = ($urandom_range(0, 15) == 0);
         wb_a = ($urandom_range(0, 2) == 0);
         wb_r_valid = ($urandom_range(0, 2) == 0);
         wb_r = 4'($urandom);
         #1;
         d = ref_decode(in_instr, 16);
         hz = 1'b0;
`ifdef DECODE_SCOREBOARD_EN
         hz = in_valid &&
              ((d.rd_a && ((m_pa && !wb_a) || (m_ov && m_held.wr_a))) ||
               (d.rd_r && ((m_pr[d.r] && !(wb_r_valid && wb_r == d.r)) || (m_ov && m_held.wr_r && m_held.r == d.r))));
`endif
         exp_rdy = !(m_ov && m_held.hlt) && (!m_ov || out_ready) && !hz && !flush;
         checks++; if (in_ready !== exp_rdy) begin
            failures++; $display("FAIL rand_in_ready n=%0d instr=%h got=%b exp=%b", n, in_instr, in_ready, exp_rdy); end
         take = in_valid && exp_rdy;
         xfer = m_ov && out_ready && !flush;
`ifdef DECODE_SCOREBOARD_EN
         if (wb_a) m_pa = 1'b0;
         if (wb_r_valid) m_pr[wb_r] = 1'b0;
         if (xfer && m_held.wr_a) m_pa = 1'b1;
         if (xfer && m_held.wr_r) m_pr[m_held.r] = 1'b1;
`endif
         if (take) begin
            m_held = d; m_pc = in_pc; m_ov = 1'b1;
         end else if (xfer || flush) begin
            m_ov = 1'b0;
         end
         step();
      end
      in_valid = 1'b0; flush = 1'b0; wb_a = 1'b0; wb_r_valid = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      wb_a = 1'b0; wb_r_valid = 1'b0; wb_r = 4'd0; in_instr = 8'h00; in_pc = 8'h00;
      step();
      step();
      rst = 1'b0;
      #1;
      test_reset();
      test_clear();
      test_hold();
      test_hazard();
      test_num_reg4();
      test_halt();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The parameter list SHALL be: NUM_REG, default 16, register-file size (2, 4, 8 or 16); PC_W, default 8, width of the PC tag; RW, derived, $clog2(NUM_REG).
REQ-002 The port list SHALL be, clock and reset first:
  clk  in  1  single clock; all state updates on the rising edge
  rst  in  1  synchronous reset, active-high
  in_valid  in  1  fetch offers an instruction
  in_ready  out  1  decode accepts this cycle
  in_instr  in  8  instruction byte
  in_pc  in  PC_W  PC of in_instr
  out_valid  out  1  decoded instruction held
  out_ready  in  1  execute consumes this cycle
  out_pc  out  PC_W  PC of held instruction
  read_a, write_a, read_r, write_r, use_immdt  out  1 each  operand controls
  r  out  RW  register index
  immdt  out  4  instr[3:0]
  shift  out  2  instr[5:4]
  alu_op  out  nand_cpu_pkg::ALU_OP  ALU operation
  is_br, is_jrl, is_ld, is_st, interrupt, halt, illegal  out  1 each  class flags
  wb_a  in  1  accumulator write retired
  wb_r_valid  in  1  register write retired
  wb_r  in  RW  retired register index
  flush  in  1  discard held instruction
  halted  out  1  HLT has issued; sticky

Function
REQ-003 Decode SHALL use the 8-bit map: 00000000 CL; 0000rrrr CP; 0001 NND; 0010 LS; 0011 RS; 0100 EQ; 0101 NE; 0110 BR; 0111 JRL; 10ssiiii LI; 1100 LD; 1101 ST; 1110 INT; 1111 HLT. CL takes priority over CP.
REQ-004 Per-opcode read_a/write_a/read_r/write_r/use_immdt SHALL be: CL 0/1/0/0/0; CP 1/0/0/1/0; NND, LS, RS, LD 1/1/1/0/0; EQ, NE, ST 1/0/1/0/0; BR 0/0/1/0/0; JRL 0/0/1/1/0; LI 1/1/0/0/1; INT, HLT 0/0/0/0/1.
REQ-005 alu_op SHALL be ALU_CLR, CP, NAND, LS, RS, EQ, NE or LI for the matching opcodes, and ALU_CLR for all other opcodes.
REQ-006 r SHALL be instr[RW-1:0].
REQ-007 illegal SHALL be 1 when read_r or write_r is 1 and instr[3:RW] is nonzero (NUM_REG<16 only). When illegal is 1, all read/write enables SHALL be 0 and all class flags other than illegal SHALL be 0.
REQ-008 The decode result and in_pc SHALL be registered: a handshake in cycle N SHALL give out_valid=1 with those fields in cycle N+1 (latency 1).
REQ-009 The output register SHALL hold its contents stable while out_valid=1 and out_ready=0.
REQ-010 in_ready SHALL be !halted && !(out_valid && halt) && (!out_valid || out_ready) && !hazard, where hazard is as defined in REQ-013.
REQ-011 halted SHALL set in the cycle after HLT transfers out (out_valid && out_ready && halt) and SHALL stay 1 until rst.
REQ-012 flush SHALL clear out_valid next cycle and SHALL force in_ready=0 in the flush cycle. A flushed HLT SHALL NOT set halted.
REQ-013 Scoreboard: one pending bit per register plus one bit for A.
  - Set: on out_valid && out_ready, for r when write_r=1 and for A when write_a=1.
  - Clear: on wb_r_valid (bit wb_r) and on wb_a (bit A).
  - Set and clear of the same bit in the same cycle: set wins.
  - hazard = in_valid AND the incoming decode reads a register or A that is pending (after same-cycle clears) or is written by the valid output-register instruction.
REQ-014 FSM states: RUN (in_ready per REQ-010), STALL (hazard=1, in_ready=0), HALTED (in_ready=0, out_valid=0 once drained). Transitions: RUN->STALL on hazard; STALL->RUN when hazard clears; any->HALTED per REQ-011; HALTED exits only on rst.

Reset
REQ-015 While rst=1 at a clock edge, out_valid, halted, all scoreboard bits and all decoded fields SHALL be 0, the FSM SHALL be RUN, and in_ready SHALL be 0 during the rst cycle.
REQ-016 Reset asserted mid-stall or mid-transfer SHALL discard the held instruction with no scoreboard residue.

Configuration
REQ-017 Macro DECODE_SCOREBOARD_EN: when defined, REQ-013 is implemented and STALL is reachable.
REQ-018 When DECODE_SCOREBOARD_EN is undefined, hazard SHALL be constant 0, no scoreboard storage SHALL exist, and wb_a, wb_r_valid and wb_r SHALL be ignored.

Verification
REQ-019 The bench SHALL cover these scenarios:
  - Reset, then in_instr=8'h00 with in_valid=1 -> next cycle out_valid=1, write_a=1, alu_op=ALU_CLR.
  - Macro defined: issue 8'h05 (CP r5); then offer 8'h15 (NND r5) -> in_ready=0 until wb_r_valid=1 with wb_r=5; accepted that same cycle.
  - NUM_REG=4: in_instr=8'h17 -> illegal=1, read_r=0; in_instr=8'h13 -> illegal=0, r=3.
  - out_ready=0 for 3 cycles with 8'hA7 held -> fields stable; use_immdt=1, immdt=7, shift=2.
  - HLT (8'hF0) held, flush=1 -> out_valid=0, halted=0; HLT again with out_ready=1 -> halted=1, in_ready stays 0 until rst.
